ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
Game controller for the tic-tac-toe datapath. Owns the 9-cell board register and accepts alternating player moves through a valid/ready handshake. After every accepted move it time-shares a single winner_detect line checker across the 8 board lines, one line per cycle, and reports win, draw or continue. Sits between the player input front-end and the display/status logic.

Parameters:
FIRST_PLAYER, 2'b01, mark of the player who moves first after reset/new_game (2'b01 = P1, 2'b10 = P2).
CNT_W, 8, width of score counters (used only with SCORE_COUNT_EN).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
new_game  in  1  synchronous clear of the current game, highest priority.
move_valid  in  1  move request.
move_player  in  2  mark of the requester: 01 = P1, 10 = P2.
move_cell  in  4  target cell, 0..8.
move_ready  out  1  high only in WAIT.
move_ack  out  1  1-cycle pulse: move accepted.
move_err  out  1  1-cycle pulse: move rejected.
board  out  18  cell i = board[2i+1:2i]; 00 = empty.
turn  out  2  mark expected next.
game_over  out  1  game finished (win or draw).
winner  out  2  winning mark; 00 if none.
draw  out  1  board full with no winner.

Behaviour:
- Reset (async, rst_n = 0): board = 0, turn = FIRST_PLAYER, move_count = 0, state = WAIT. Outputs: move_ack = 0, move_err = 0, game_over = 0, winner = 00, draw = 0.
- States: WAIT, SCAN, DONE.
- WAIT: move_ready = 1. A handshake occurs when move_valid & move_ready.
  - Reject if move_player != turn, move_cell > 8, or the target cell is non-zero. On reject: move_err pulses the next cycle; board unchanged; state stays WAIT.
  - Otherwise: the cell is written with move_player, move_count increments, move_ack pulses the next cycle, and the state goes to SCAN with line_idx = 0.
- SCAN: move_ready = 0; move_valid is ignored (no ack, no err).
  - Each cycle, the three cells of lines[line_idx] drive the checker. The checker outputs winner = 1 when all three cells are equal and non-zero, and who = that mark.
  - Line order: 0:(0,1,2) 1:(3,4,5) 2:(6,7,8) 3:(0,3,6) 4:(1,4,7) 5:(2,5,8) 6:(0,4,8) 7:(2,4,6).
  - On a hit: the registered winner = who, game_over = 1, go to DONE. Early exit; remaining lines are not scanned.
  - Line 7 with no hit: if move_count == 9, draw = 1, game_over = 1, go to DONE. Else toggle turn (01<->10) and go to WAIT.
- Timing, with the move accepted at edge T:
  - Scan of line k occurs in cycle T+1+k.
  - A win on line k shows game_over at T+k+2.
  - With no win, move_ready re-asserts at T+9; a draw shows at T+9.
- DONE: move_ready = 0; outputs hold until new_game or reset.
- A win on the 9th move reports winner, draw = 0 (win has precedence).
- new_game (any state, including mid-SCAN): next edge performs the reset-equivalent clear. A move_valid in the same cycle is ignored.
- rst_n asserted mid-SCAN: immediate clear; no stale game_over.

Optional Feature:
SCORE_COUNT_EN.
- Defined: adds outputs p1_wins, p2_wins, draws [CNT_W-1:0]. Each increments once on entry to DONE, according to the result, and saturates at all-ones. Cleared only by rst_n; new_game does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ttt_pkg holds:
  - Mark constants EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10.
  - State encodings WAIT/SCAN/DONE.
  - The 8-entry line-to-cell-index table.
- One sub-module: a single existing winner_detect instance as the line checker, fed by a line_idx-indexed cell mux.
- Board, FSM and counters live in ttt_game_ctrl.

Test Plan:
- Reset check: after rst_n release, expect board = 0, turn = 01, move_ready = 1, game_over = 0, winner = 00.
- Illegal moves:
  - P2 moves first -> move_err pulse, board = 0.
  - P1 takes cell 4, then P2 takes cell 4 -> move_err.
  - move_cell = 9 -> move_err; turn unchanged.
- Row win: P1 0, P2 3, P1 1, P2 4, P1 2 -> game_over at T+2 after the last accept (line 0), winner = 01, move_ready = 0.
- Draw: P1 0, P2 1, P1 2, P2 4, P1 3, P2 5, P1 7, P2 6, P1 8 -> after the last accept, at T+9: draw = 1, winner = 00, game_over = 1.
- Late-line win: P1 0, P2 2, P1 1, P2 4, P1 8, P2 6 -> hit on line 7, game_over at T+9, winner = 10.
- Clears:
  - new_game asserted during SCAN -> next cycle board = 0, state WAIT, turn = FIRST_PLAYER, no game_over.
  - rst_n pulsed mid-SCAN -> immediate clear.
  - With SCORE_COUNT_EN defined, the score counters survive new_game.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe controller.
//   - mark constants (EMPTY/P1/P2)
//   - controller state encoding (WAIT/SCAN/DONE)
//   - line-to-cell table (line_cells), scanned in index order 0..7
package ttt_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Cell indices of one line, packed as {c2, c1, c0}.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        logic [11:0] r;
        case (idx)
            3'd0:    r = {4'd2, 4'd1, 4'd0};
            3'd1:    r = {4'd5, 4'd4, 4'd3};
            3'd2:    r = {4'd8, 4'd7, 4'd6};
            3'd3:    r = {4'd6, 4'd3, 4'd0};
            3'd4:    r = {4'd7, 4'd4, 4'd1};
            3'd5:    r = {4'd8, 4'd5, 4'd2};
            3'd6:    r = {4'd8, 4'd4, 4'd0};
            default: r = {4'd6, 4'd4, 4'd2};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_winner_detect.sv
// winner_detect: single-line checker.
//   a_i, b_i, c_i : the three cell marks of one line
//   winner_o      : all three equal and non-empty
//   who_o         : the winning mark, EMPTY when winner_o is low
module winner_detect
    import ttt_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic [1:0] c_i,
    output logic       winner_o,
    output logic [1:0] who_o
);

    assign winner_o = (a_i != EMPTY) && (a_i == b_i) && (b_i == c_i);
    assign who_o    = winner_o ? a_i : EMPTY;

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game controller.
// Owns the board, accepts alternating moves over a valid/ready handshake and,
// after each accepted move, scans the 8 lines one per cycle through a single
// winner_detect instance.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   new_game              synchronous clear, highest priority
//   move_valid/player/cell  move request; move_ready high only in WAIT
//   move_ack / move_err   1-cycle accept / reject pulses
//   board, turn           board (cell i = board[2i+1:2i]) and next mark
//   game_over, winner, draw  result
// Optional: define SCORE_COUNT_EN to add saturating p1_wins/p2_wins/draws
// counters (cleared by rst_n only).
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [1:0]  move_player,
    input  logic [3:0]  move_cell,
    output logic        move_ready,
    output logic        move_ack,
    output logic        move_err,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        draw
`ifdef SCORE_COUNT_EN
    ,
    output logic [CNT_W-1:0] p1_wins,
    output logic [CNT_W-1:0] p2_wins,
    output logic [CNT_W-1:0] draws
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    function automatic logic [1:0] cell_at(input logic [17:0] brd, input logic [3:0] idx);
        return brd[{idx, 1'b0} +: 2];
    endfunction

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [1:0]  turn_q, turn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  line_q, line_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic        over_q, over_d, draw_q, draw_d;
    logic [1:0]  winner_q, winner_d;
    // Registered checker result: the decision for line k is taken one cycle
    // after that line was presented to the checker.
    logic        chk_vld_q, chk_vld_d, chk_hit_q, chk_hit_d, chk_last_q, chk_last_d;
    logic [1:0]  chk_who_q, chk_who_d;

    logic [11:0] cells;
    logic        hit;
    logic [1:0]  who;
    logic        legal;

    assign cells = line_cells(line_q);

    winner_detect u_chk (
        .a_i      (cell_at(board_q, cells[3:0])),
        .b_i      (cell_at(board_q, cells[7:4])),
        .c_i      (cell_at(board_q, cells[11:8])),
        .winner_o (hit),
        .who_o    (who)
    );

    assign legal = (move_player == turn_q) && (move_cell <= 4'd8) &&
                   (cell_at(board_q, move_cell) == EMPTY);

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        over_d     = over_q;
        winner_d   = winner_q;
        draw_d     = draw_q;
        chk_vld_d  = 1'b0;
        chk_hit_d  = hit;
        chk_who_d  = who;
        chk_last_d = (line_q == 3'd7);

        if (new_game) begin
            state_d  = WAIT;
            board_d  = '0;
            turn_d   = FIRST_PLAYER;
            cnt_d    = '0;
            line_d   = '0;
            over_d   = 1'b0;
            winner_d = EMPTY;
            draw_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (move_valid) begin
                        if (legal) begin
                            board_d[{move_cell, 1'b0} +: 2] = move_player;
                            cnt_d   = cnt_q + 4'd1;
                            ack_d   = 1'b1;
                            line_d  = '0;
                            state_d = SCAN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    chk_vld_d = 1'b1;
                    line_d    = line_q + 3'd1;
                    if (chk_vld_q) begin
                        if (chk_hit_q) begin
                            winner_d = chk_who_q;
                            over_d   = 1'b1;
                            state_d  = DONE;
                        end else if (chk_last_q) begin
                            if (cnt_q == 4'd9) begin
                                draw_d  = 1'b1;
                                over_d  = 1'b1;
                                state_d = DONE;
                            end else begin
                                turn_d  = (turn_q == P1) ? P2 : P1;
                                state_d = WAIT;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT;
            board_q    <= '0;
            turn_q     <= FIRST_PLAYER;
            cnt_q      <= '0;
            line_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= EMPTY;
            draw_q     <= 1'b0;
            chk_vld_q  <= 1'b0;
            chk_hit_q  <= 1'b0;
            chk_who_q  <= EMPTY;
            chk_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
            draw_q     <= draw_d;
            chk_vld_q  <= chk_vld_d;
            chk_hit_q  <= chk_hit_d;
            chk_who_q  <= chk_who_d;
            chk_last_q <= chk_last_d;
        end
    end

    assign move_ready = (state_q == WAIT);
    assign move_ack   = ack_q;
    assign move_err   = err_q;
    assign board      = board_q;
    assign turn       = turn_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign draw       = draw_q;

`ifdef SCORE_COUNT_EN
    logic [CNT_W-1:0] p1_q, p2_q, dr_q;
    logic             enter_done;

    // new_game forces WAIT, so a cleared cycle never counts as an entry.
    assign enter_done = (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= '0;
            p2_q <= '0;
            dr_q <= '0;
        end else if (enter_done) begin
            if (draw_d && !(&dr_q))                 dr_q <= dr_q + 1'b1;
            if (winner_d == P1 && !(&p1_q))         p1_q <= p1_q + 1'b1;
            if (winner_d == P2 && !(&p2_q))         p2_q <= p2_q + 1'b1;
        end
    end

    assign p1_wins = p1_q;
    assign p2_wins = p2_q;
    assign draws   = dr_q;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;

    localparam logic [1:0] FP = 2'b01;
    localparam int EV_ACK = 0, EV_ERR = 1, EV_OVER = 2, EV_READY = 3;

    logic        clk = 1'b0, rst_n = 1'b0, new_game = 1'b0, move_valid = 1'b0;
    logic [1:0]  move_player = 2'b00;
    logic [3:0]  move_cell = 4'd0;
    logic        move_ready, move_ack, move_err, game_over, draw;
    logic [17:0] board;
    logic [1:0]  turn, winner;
`ifdef SCORE_COUNT_EN
    logic [7:0]  p1_wins, p2_wins, draws;
`endif

    ttt_game_ctrl #(.FIRST_PLAYER(FP), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
        .move_player(move_player), .move_cell(move_cell), .move_ready(move_ready),
        .move_ack(move_ack), .move_err(move_err), .board(board), .turn(turn),
        .game_over(game_over), .winner(winner), .draw(draw)
`ifdef SCORE_COUNT_EN
        , .p1_wins(p1_wins), .p2_wins(p2_wins), .draws(draws)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct {
        int          kind;
        int          cyc;
        logic [17:0] board;
        logic [1:0]  turn;
        logic        over;
        logic [1:0]  winner;
        logic        dr;
        logic        rdy;
    } ev_t;
    ev_t sb[$];

    // ---------------- reference model (game rules) ----------------
    int         LN[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [1:0] bd[9];
    logic [1:0] mturn;
    int         mcnt;
    bit         mover;
    int         mp1 = 0, mp2 = 0, mdr = 0;

    function automatic logic [17:0] pack_bd();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = bd[i];
        return b;
    endfunction

    function automatic int find_win();
        for (int l = 0; l < 8; l++)
            if (bd[LN[l][0]] != 2'b00 && bd[LN[l][0]] == bd[LN[l][1]] && bd[LN[l][1]] == bd[LN[l][2]])
                return l;
        return -1;
    endfunction

    function automatic logic [1:0] other(input logic [1:0] p);
        return (p == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) bd[i] = 2'b00;
        mturn = FP; mcnt = 0; mover = 0;
    endtask

    task automatic push(input int k, input int c, input logic [17:0] b, input logic [1:0] t,
                        input logic o, input logic [1:0] w, input logic d, input logic r);
        ev_t e;
        e.kind = k; e.cyc = c; e.board = b; e.turn = t;
        e.over = o; e.winner = w; e.dr = d; e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    bit   hold = 1'b1;
    logic prev_ready = 1'b0, prev_over = 1'b0;

    task automatic expect_ev(input int k, input string nm);
        ev_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: unexpected event, nothing queued (cycle %0d)", nm, cyc);
            return;
        end
        e = sb.pop_front();
        chk({nm, ".kind"}, k, e.kind);
        chk({nm, ".cycle"}, cyc, e.cyc);
        chk({nm, ".board"}, board, e.board);
        chk({nm, ".turn"}, turn, e.turn);
        chk({nm, ".game_over"}, game_over, e.over);
        chk({nm, ".winner"}, winner, e.winner);
        chk({nm, ".draw"}, draw, e.dr);
        chk({nm, ".move_ready"}, move_ready, e.rdy);
    endtask

    always @(negedge clk) begin
        if (!hold) begin
            if (move_ack === 1'b1) expect_ev(EV_ACK, "ack");
            if (move_err === 1'b1) expect_ev(EV_ERR, "err");
            if (game_over === 1'b1 && prev_over !== 1'b1) expect_ev(EV_OVER, "over");
            if (move_ready === 1'b1 && prev_ready !== 1'b1) expect_ev(EV_READY, "ready");
        end
        prev_ready = move_ready;
        prev_over  = game_over;
    end

    // ---------------- driver ----------------
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (move_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_ready: move_ready stuck at %b, required 1 within 40 cycles", move_ready);
        end
    endtask

    task automatic recover();
        hold = 1'b1;
        sb.delete();
        @(negedge clk); new_game = 1'b1;
        @(posedge clk); #1; new_game = 1'b0;
        model_clear();
        @(negedge clk); hold = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] p, input logic [3:0] c, input bit abort_en);
        int T, R, E, k; bit legal, ok;
        wait_ready(ok);
        if (!ok) begin recover(); return; end
        T = cyc + 1;
        legal = 0;
        if (p == mturn && c <= 4'd8) legal = (bd[c] == 2'b00);
        move_valid = 1'b1; move_player = p; move_cell = c;
        if (!legal) begin
            push(EV_ERR, T, pack_bd(), mturn, 0, 2'b00, 0, 1);
        end else begin
            bd[c] = p; mcnt++;
            push(EV_ACK, T, pack_bd(), mturn, 0, 2'b00, 0, 0);
            k = find_win();
            R = (k >= 0) ? T + k + 2 : T + 9;
            if (abort_en) begin
                E = T + 1 + int'($urandom_range(0, R - T - 1));
                push(EV_READY, E, 18'd0, FP, 0, 2'b00, 0, 1);
                model_clear();
            end else if (k >= 0) begin
                push(EV_OVER, R, pack_bd(), mturn, 1, p, 0, 0);
                mover = 1;
                if (p == 2'b01) mp1++; else mp2++;
            end else if (mcnt == 9) begin
                push(EV_OVER, R, pack_bd(), mturn, 1, 2'b00, 1, 0);
                mover = 1; mdr++;
            end else begin
                mturn = other(mturn);
                push(EV_READY, R, pack_bd(), mturn, 0, 2'b00, 0, 1);
            end
        end
        @(posedge clk); #1;
        if (legal && abort_en) begin
            while (cyc < E - 1) begin
                move_valid = 1'(($urandom_range(0, 1)));
                move_player = 2'($urandom_range(1, 2));
                move_cell = 4'($urandom_range(0, 8));
                @(negedge clk);
            end
            new_game = 1'b1; move_valid = 1'b1;
            @(posedge clk); #1;
            new_game = 1'b0; move_valid = 1'b0;
        end else if (legal) begin
            // stray request while scanning must be ignored
            move_player = other(p); move_cell = 4'($urandom_range(0, 8));
            @(posedge clk); #1;
            move_valid = 1'b0;
        end else begin
            move_valid = 1'b0;
        end
    endtask

    // After a finished game: wait for the result, then start over.
    task automatic restart();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (game_over === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL restart: game_over %b, required 1 within 40 cycles", game_over);
            recover();
            return;
        end
        push(EV_READY, cyc + 1, 18'd0, FP, 0, 2'b00, 0, 1);
        new_game = 1'b1;
        @(posedge clk); #1; new_game = 1'b0;
        model_clear();
    endtask

    // Clear an unfinished game from WAIT (no ready edge expected).
    task automatic soft_clear();
        bit ok;
        wait_ready(ok);
        new_game = 1'b1;
        @(posedge clk); #1; new_game = 1'b0;
        model_clear();
    endtask

    task automatic play_seq(input int cells[9], input int n);
        for (int i = 0; i < n; i++) do_move((i % 2 == 0) ? FP : other(FP), 4'(cells[i]), 0);
        if (mover) restart(); else soft_clear();
    endtask

    initial begin
        bit ok;
        model_clear();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset.board", board, 18'd0);
        chk("reset.turn", turn, FP);
        chk("reset.move_ready", move_ready, 1'b1);
        chk("reset.game_over", game_over, 1'b0);
        chk("reset.winner", winner, 2'b00);
        chk("reset.ack_err", {move_ack, move_err}, 2'b00);
        hold = 1'b0;

        // illegal moves
        do_move(2'b10, 4'd0, 0);
        do_move(2'b01, 4'd4, 0);
        do_move(2'b10, 4'd4, 0);
        do_move(2'b10, 4'd9, 0);
        soft_clear();

        play_seq('{0,3,1,4,2,0,0,0,0}, 5);          // row 0 win
        play_seq('{0,1,2,4,3,5,7,6,8}, 9);          // draw
        play_seq('{0,2,1,4,8,6,0,0,0}, 6);          // line 7 win for P2

        // new_game mid-scan
        do_move(FP, 4'd4, 1);
        do_move(FP, 4'd0, 1);

        // async reset mid-scan
        do_move(FP, 4'd4, 0);
        hold = 1'b1;
        sb.delete();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid.board", board, 18'd0);
        chk("rst_mid.move_ready", move_ready, 1'b1);
        chk("rst_mid.game_over", game_over, 1'b0);
        chk("rst_mid.turn", turn, FP);
        chk("rst_mid.winner", winner, 2'b00);
        #1 rst_n = 1'b1;
        model_clear();
        mp1 = 0; mp2 = 0; mdr = 0;
        @(negedge clk); hold = 1'b0;

        // random games
        for (int g = 0; g < 30; g++) begin
            int a = 0;
            while (!mover && a < 30) begin
                logic [1:0] p;
                logic [3:0] c;
                p = ($urandom_range(0, 99) < 85) ? mturn : other(mturn);
                c = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
                do_move(p, c, $urandom_range(0, 99) < 8);
                a++;
            end
            if (mover) restart(); else soft_clear();
        end

        wait_ready(ok);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard.drained", sb.size(), 0);
`ifdef SCORE_COUNT_EN
        chk("score.p1_wins", p1_wins, mp1[7:0]);
        chk("score.p2_wins", p2_wins, mp2[7:0]);
        chk("score.draws", draws, mdr[7:0]);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
